// File: rtl/core8_dbg_pkg.sv
// Shared types and defaults for the 8-core debug halt sequencer.
package core8_dbg_pkg;

    localparam int DEF_NUM_CORES   = 8;
    localparam int DEF_TIMEOUT_W   = 8;
    localparam int DEF_ACK_TIMEOUT = 200;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HALTING  = 3'd1,
        ST_HALTED   = 3'd2,
        ST_RESUMING = 3'd3,
        ST_ERROR    = 3'd4
    } dbg_state_e;

endpackage

// File: rtl/core8_dbg_ack_timer.sv
// Saturating acknowledge timer: clear > load > count; expired flags the limit.
module core8_dbg_ack_timer #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (load_val > MAX) ? MAX : load_val;
        end else if (en && (cnt != MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == MAX);

endmodule

// File: rtl/core8_debug_halt_sequencer.sv
// Global halt/resume sequencer over per-core debugreq/debugack handshakes.
// Optional cross-trigger (unsolicited ack halts all masked cores): CORE8_DBG_CROSS_TRIGGER_EN.
module core8_debug_halt_sequencer
    import core8_dbg_pkg::*;
#(
    parameter int NUM_CORES   = DEF_NUM_CORES,
    parameter int TIMEOUT_W   = DEF_TIMEOUT_W,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 halt_req,
    input  logic                 resume_req,
    input  logic                 clear_err,
    input  logic [NUM_CORES-1:0] core_mask,
    input  logic [NUM_CORES-1:0] debugack,
    output logic [NUM_CORES-1:0] debugreq,
    output logic                 all_halted,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [NUM_CORES-1:0] stuck_mask,
    output logic [2:0]           state_o
`ifdef CORE8_DBG_CROSS_TRIGGER_EN
   ,output logic [NUM_CORES-1:0] trig_src
`endif
);

    dbg_state_e           state_q;
    logic [NUM_CORES-1:0] mask_q;
    logic [NUM_CORES-1:0] ack_q;
    logic                 done_h, done_r;
    logic                 go_halt;
    logic                 tmr_run, tmr_expired;

    assign done_h = ((ack_q & mask_q) == mask_q);
    assign done_r = ((ack_q & mask_q) == '0);

`ifdef CORE8_DBG_CROSS_TRIGGER_EN
    logic [NUM_CORES-1:0] ack_prev;
    logic [NUM_CORES-1:0] trig_rise;
    // A masked core dropping into debug on its own counts as a halt request.
    assign trig_rise = ack_q & ~ack_prev & core_mask;
    assign go_halt   = halt_req | (|trig_rise);
`else
    assign go_halt   = halt_req;
`endif

    // Counter only runs while waiting on acks; it sits at zero otherwise.
    assign tmr_run = (state_q == ST_HALTING) || (state_q == ST_RESUMING);

    core8_dbg_ack_timer #(
        .W   (TIMEOUT_W),
        .MAX (TIMEOUT_W'(ACK_TIMEOUT))
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (!tmr_run),
        .en       (tmr_run),
        .load     (1'b0),
        .load_val ('0),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            ack_q       <= '0;
            debugreq    <= '0;
            all_halted  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            stuck_mask  <= '0;
`ifdef CORE8_DBG_CROSS_TRIGGER_EN
            ack_prev    <= '0;
            trig_src    <= '0;
`endif
        end else begin
            ack_q <= debugack;
`ifdef CORE8_DBG_CROSS_TRIGGER_EN
            ack_prev <= ack_q;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (go_halt) begin
                        state_q  <= ST_HALTING;
                        mask_q   <= core_mask;
                        debugreq <= core_mask;
                        busy     <= 1'b1;
`ifdef CORE8_DBG_CROSS_TRIGGER_EN
                        trig_src <= trig_rise;
`endif
                    end
                end
                ST_HALTING: begin
                    // Full ack set wins over a coincident timeout.
                    if (done_h) begin
                        state_q    <= ST_HALTED;
                        busy       <= 1'b0;
                        all_halted <= 1'b1;
                    end else if (tmr_expired) begin
                        state_q     <= ST_ERROR;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        stuck_mask  <= mask_q & ~ack_q;
                        debugreq    <= '0;
                    end
                end
                ST_HALTED: begin
                    if (resume_req) begin
                        state_q    <= ST_RESUMING;
                        debugreq   <= '0;
                        all_halted <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                ST_RESUMING: begin
                    if (done_r) begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
`ifdef CORE8_DBG_CROSS_TRIGGER_EN
                        trig_src <= '0;
`endif
                    end else if (tmr_expired) begin
                        state_q     <= ST_ERROR;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        stuck_mask  <= mask_q & ack_q;
                    end
                end
                ST_ERROR: begin
                    if (clear_err) begin
                        state_q     <= ST_IDLE;
                        timeout_err <= 1'b0;
                        stuck_mask  <= '0;
`ifdef CORE8_DBG_CROSS_TRIGGER_EN
                        trig_src    <= '0;
`endif
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    debugreq    <= '0;
                    all_halted  <= 1'b0;
                    busy        <= 1'b0;
                    timeout_err <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state_q;

endmodule
